alu_issue: RTL
==============

# alu_issue

Instruction issue and writeback stage sitting directly upstream of the 4-bit combinational ALU (`alu`). It accepts encoded instructions through a valid/ready handshake into a 2-entry queue. It reads operands from a 4x4-bit register file and drives the ALU operand and control inputs. It then captures the ALU result and flags, and writes them back to the destination register and a registered flags word.

## Interface
- No parameters; widths are fixed by the ALU (4-bit data, 2-bit op).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  queue can accept; transfer when `in_valid & in_ready` at rising edge.
- `in_instr`  in  13  `[12]` ld, `[11]` l, `[10:9]` alu_op, `[8]` imm_sel, `[7:6]` rd, `[5:4]` rs, `[3:0]` rt (`[1:0]`) or imm.
- `alu_a`, `alu_b`  out  4  operands to ALU `A`, `B`.
- `alu_op`  out  2  to ALU `ALUOp`.
- `alu_l`  out  1  to ALU `l` (0 arithmetic, 1 logic).
- `alu_r`  in  4  ALU `R`.
- `alu_zero`, `alu_carry`, `alu_sign`  in  1  ALU flags.
- `flags_q`  out  3  registered {zero, carry, sign}.
- `done`  out  1  one-cycle pulse on each writeback.
- `busy`  out  1  FSM not IDLE or queue non-empty.
- `dbg_sel`  in  2  register-file read select.
- `dbg_data`  out  4  combinational `rf[dbg_sel]`.

## Operation
- Queue: 2-entry FIFO with wrap-around read/write pointers and a 2-bit count.
  - `in_ready = (count != 2) & ~reset`, computed from registered count only; a pop in the same cycle does not open a slot.
  - Simultaneous push and pop with count 1 leaves count 1.
- FSM states: IDLE, EXEC, WB.
  - IDLE -> EXEC when queue non-empty; pop head into instruction register `ir`.
  - EXEC: drive `alu_a = rf[rs]`; `alu_b = imm_sel ? imm : rf[rt]`; `alu_op`, `alu_l` from `ir`. At the edge, capture `res_q <= ld ? imm : alu_r` and flags. Next state WB.
  - WB: `rf[rd] <= res_q`; `flags_q` updated; `done = 1`. Next state EXEC if queue non-empty (pop in the same edge), else IDLE.
- Flag capture:
  - ld: flags_q unchanged.
  - l=1: zero = `alu_zero`; carry and sign forced to 0 (ALU drives X there).
  - l=0: all three taken from the ALU.
- Outside EXEC: `alu_a`, `alu_b`, `alu_op`, `alu_l` driven to 0 (no X into ALU).
- Register file write port is WB only; `dbg_data` shows the new value the cycle after WB.

## Timing
- Reset values: rf all 0; flags_q 0; queue empty; state IDLE; `ir`, `res_q` 0; `done` 0; `busy` 0; ALU drives 0. `in_ready` is 0 during the reset cycle and 1 after.
- Latency: instruction accepted at edge N (queue empty, IDLE) -> popped at N+1 -> EXEC during N+1..N+2 -> WB cycle; `rf`/`flags_q` visible after edge N+3. `done` is high in the cycle between N+2 and N+3.
- Throughput: one instruction per 2 cycles while the queue stays non-empty (EXEC/WB alternate).
- Reset asserted in EXEC or WB: instruction abandoned, no rf/flags write, queue flushed.
- An instruction reading the rd written by the previous one sees the written value; WB precedes the next EXEC, so no forwarding is needed.

## Structure
- Shared package: instruction field bit positions, the state enum (IDLE/EXEC/WB), flag-bit indices, and ALUOp encodings (00 neg A, 01 neg B, 10 add, 11 sub).
- One sub-module: `instr_fifo2` (2-entry queue, push/pop/count). The register file and FSM stay inline.
- Top-level test harness instantiates `alu_issue` plus `alu`.

## Test plan
- After reset: push ld r1=5 (imm 0101) and ld r2=3 -> r1=5, r2=3; flags_q stays 000; two `done` pulses.
- add r3=r1+r2 (l=0, op 10) -> r3=8, flags_q zero=0 carry=0 sign=1.
- sub r0=r2-r2 (op 11) -> r0=0, flags_q zero=1 carry=1 sign=0.
- Logic op with immediate 0000, result 0 -> zero=1; carry and sign forced 0 (never X).
- Hold `in_valid` high with 3 back-to-back instructions while IDLE.
  - Required: `in_ready` drops once count hits 2; no instruction lost or duplicated; results written in order.
- Assert reset during EXEC of an add to r3.
  - Required: r3 stays 0, queue empty, state IDLE, `in_ready` = 1 the following cycle.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue stage: instruction field layout,
// issue FSM states, flag-word bit indices and ALUOp encodings.
package alu_issue_pkg;

    localparam int INSTR_W     = 13;
    localparam int LD_BIT      = 12;
    localparam int L_BIT       = 11;
    localparam int OP_HI       = 10;
    localparam int OP_LO       = 9;
    localparam int IMM_SEL_BIT = 8;
    localparam int RD_HI       = 7;
    localparam int RD_LO       = 6;
    localparam int RS_HI       = 5;
    localparam int RS_LO       = 4;
    localparam int RT_HI       = 1;
    localparam int RT_LO       = 0;
    localparam int IMM_HI      = 3;
    localparam int IMM_LO      = 0;

    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_SIGN  = 0;

    localparam logic [1:0] ALU_NEG_A = 2'b00;
    localparam logic [1:0] ALU_NEG_B = 2'b01;
    localparam logic [1:0] ALU_ADD   = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Logic ops leave carry/sign undefined at the ALU, so they are cleared here.
    function automatic logic [2:0] capture_flags(input logic l, input logic z,
                                                 input logic c, input logic s);
        logic [2:0] f;
        f            = 3'b000;
        f[FLAG_ZERO] = z;
        if (l) begin
            f[FLAG_CARRY] = 1'b0;
            f[FLAG_SIGN]  = 1'b0;
        end else begin
            f[FLAG_CARRY] = c;
            f[FLAG_SIGN]  = s;
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_issue_fifo2.sv
// Two-entry instruction queue with wrap-around pointers and an occupancy count.
module instr_fifo2
    import alu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] wdata,
    output logic [INSTR_W-1:0] rdata,
    output logic [1:0]         count
);

    logic [INSTR_W-1:0] mem_q [2];
    logic [INSTR_W-1:0] mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               push_ok_s, pop_ok_s;

    // Next-state computation for storage, pointers and count.
    always_comb begin
        push_ok_s = push & (count_q != 2'd2);
        pop_ok_s  = pop & (count_q != 2'd0);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= {INSTR_W{1'b0}};
            mem_q[1] <= {INSTR_W{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the 4-bit ALU: queues instructions, reads
// operands from a 4x4 register file, and writes back result and flags.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [1:0]         alu_op,
    output logic               alu_l,
    input  logic [3:0]         alu_r,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_sign,
    output logic [2:0]         flags_q,
    output logic               done,
    output logic               busy,
    input  logic [1:0]         dbg_sel,
    output logic [3:0]         dbg_data
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [3:0]         res_q, res_d;
    logic [2:0]         res_flags_q, res_flags_d;
    logic [2:0]         flags_d;
    logic               done_q, done_d;
    logic [3:0]         rf_q [4];
    logic [3:0]         rf_d [4];

    logic               push_s;
    logic               pop_s;
    logic [INSTR_W-1:0] head_s;
    logic [1:0]         count_s;
    logic [3:0]         imm_s;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign in_ready = (count_s != 2'd2) & ~reset;
    assign push_s   = in_valid & in_ready;
    assign imm_s    = ir_q[IMM_HI:IMM_LO];

    instr_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_instr),
        .rdata (head_s),
        .count (count_s)
    );

    // Issue FSM next-state, ALU drive, result capture and writeback.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        res_d       = res_q;
        res_flags_d = res_flags_q;
        flags_d     = flags_q;
        rf_d        = rf_q;
        done_d      = 1'b0;
        pop_s       = 1'b0;
        alu_a       = 4'd0;
        alu_b       = 4'd0;
        alu_op      = 2'd0;
        alu_l       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_s != 2'd0) begin
                    pop_s   = 1'b1;
                    ir_d    = head_s;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                alu_a = rf_q[ir_q[RS_HI:RS_LO]];
                if (ir_q[IMM_SEL_BIT]) begin
                    alu_b = imm_s;
                end else begin
                    alu_b = rf_q[ir_q[RT_HI:RT_LO]];
                end
                alu_op = ir_q[OP_HI:OP_LO];
                alu_l  = ir_q[L_BIT];
                if (ir_q[LD_BIT]) begin
                    res_d = imm_s;
                end else begin
                    res_d = alu_r;
                end
                res_flags_d = capture_flags(ir_q[L_BIT], alu_zero, alu_carry, alu_sign);
                done_d      = 1'b1;
                state_d     = ST_WB;
            end
            ST_WB: begin
                rf_d[ir_q[RD_HI:RD_LO]] = res_q;
                if (ir_q[LD_BIT]) begin
                    flags_d = flags_q;
                end else begin
                    flags_d = res_flags_q;
                end
                if (count_s != 2'd0) begin
                    pop_s   = 1'b1;
                    ir_d    = head_s;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pipeline, register-file and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ir_q        <= {INSTR_W{1'b0}};
            res_q       <= 4'd0;
            res_flags_q <= 3'd0;
            flags_q     <= 3'd0;
            done_q      <= 1'b0;
            rf_q[0]     <= 4'd0;
            rf_q[1]     <= 4'd0;
            rf_q[2]     <= 4'd0;
            rf_q[3]     <= 4'd0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            res_q       <= res_d;
            res_flags_q <= res_flags_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            rf_q        <= rf_d;
        end
    end

    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE) | (count_s != 2'd0);
    assign dbg_data = rf_q[dbg_sel];

endmodule
